decode_stage_fwd: RTL and testbench
===================================

# decode_stage_fwd

Parametrised decode stage: accepts 16-bit instructions over a valid/ready handshake, reads an internal register file, resolves operands through N forwarding ports plus the writeback port, and registers the decoded bundle for execute. It adds back-pressure, branch flush, configurable register width and count, and an optional load-use scoreboard interlock.

## Interface
- `XLEN`, 16: register and operand width, at least 16.
- `NREGS`, 8: register count, a power of two; `RA = $clog2(NREGS)`, at most 3 for the fixed instruction format.
- `NFWD`, 2: number of forwarding ports, at least 1.
- `LOAD_OPC`, 4'hA: opcode that marks a load, used by the scoreboard.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction valid.
- `in_ready` out 1: stage can accept.
- `instr` in 16: fields are opcode[15:12], imm_flag[11], rd[10:8], rs1[7:5], rs2[4:2], imm[4:0].
- `flush` in 1: branch taken; kill the stage.
- `fwd_valid` in NFWD: forward entry i is valid.
- `fwd_rd` in NFWD*RA: destination register of entry i.
- `fwd_data` in NFWD*XLEN: value of entry i.
- `wb_we` in 1: register-file write enable.
- `wb_rd` in RA: write address.
- `wb_data` in XLEN: write data.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `opcode` out 4, `imm_flag` out 1, `imm` out 5, `rd` out RA: decoded fields.
- `op1`, `op2` out XLEN: resolved operands.
- `branch_target` out XLEN: instr[10:0] zero-extended.
- `instr_out` out 16: the raw instruction.

## Operation
- Accept occurs when `in_valid && in_ready`. Fields are decoded and operands resolved in that cycle, then captured into the output register.
- `op1` source priority for rs1:
  - `fwd` entry 0 through NFWD-1 with a matching rd; the lowest index wins.
  - `wb_we && wb_rd==rs1`, as write-through.
  - Register file.
- `op2`:
  - `imm_flag=1`: `{zeros, imm}`.
  - Otherwise the same priority as `op1`, applied to rs2.
- Register file:
  - Written on `wb_we`.
  - All entries are 0 after reset.
  - r0 is not hardwired.
- Captured operands are not refreshed while the bundle is held; execute bypasses any later producers.
- `in_ready = (!out_valid || out_ready) && !flush && !hazard`, where hazard is defined under Configuration.
- `flush`:
  - The instruction presented that cycle is dropped.
  - `out_valid` is 0 next cycle.
  - Scoreboard bits are untouched.
  - `flush` has priority over accept and over holding a stalled bundle.

## Timing
- Reset: `out_valid=0`; all bundle outputs 0; `in_ready=0` while `reset_n` is low; scoreboard cleared.
- Latency: an instruction accepted at edge k is presented with `out_valid=1` after edge k.
- Hold: while `out_valid && !out_ready`, every output is stable.
- Throughput: one instruction per cycle when `out_ready=1` and there is no hazard.
- Simultaneous:
  - Accept plus output handshake in the same cycle: the new bundle replaces the old one, with no bubble.
  - Flush plus `out_ready`: the held bundle is consumed, and the output is invalid next cycle.
- Reset asserted mid-stream: the output is invalidated immediately (asynchronously). The in-flight bundle is lost.

## Configuration
- `DECODE_SCOREBOARD_EN` defined:
  - Keep an `NREGS`-bit busy vector. A bit is set when a `LOAD_OPC` bundle completes the output handshake (bit `rd`), and cleared on `wb_we` at `wb_rd`. If set and clear hit the same register in the same cycle, set wins.
  - `hazard` is true when a used source (rs1; rs2 only when `imm_flag=0`) matches either of:
    - its busy bit, unless `wb_we` clears it this cycle;
    - the rd of a valid held `LOAD_OPC` bundle in the output register.
- Not defined: `hazard=0`, there is no busy vector, and load-use interlock is execute's responsibility.

## Structure
- `decode_pkg` holds:
  - instruction field positions (`OPC_HI/LO`, `IMMF_BIT`, `RD_LO`, `RS1_LO`, `RS2_LO`, `IMM_W`);
  - opcode constants, including the default `LOAD_OPC`;
  - a `decoded_t` bundle struct.
- Sub-module `decode_regfile`:
  - `NREGS` x `XLEN`;
  - two combinational read ports and one write port;
  - async active-low reset to zero;
  - write-through bypass inside.

## Test plan
- Reset, then r2=5 and r3=7 via wb; send `instr` 16'h1148 (op1 r2, op2 r2 reg form) -> `op1=op2=5` one cycle later, and `branch_target=16'h0148`.
- Immediate form 16'h1857 -> `imm_flag=1`, `op2=16'h0017`, `op1=R[2]`.
- Forwarding with `fwd_valid=2'b11`, both `fwd_rd=2`, data 16'hAAAA (i0) and 16'hBBBB (i1), plus `wb_we` to r2 with 16'hCCCC -> `op1=16'hAAAA`. With only wb active -> `op1=16'hCCCC`.
- Hold `out_ready=0` for 3 cycles with `in_valid=1` -> `in_ready=0` and outputs stable. Release -> next instruction is accepted in the same cycle, with no bubble.
- Flush while the output is held and a new instruction is presented -> `out_valid=0` next cycle, the new instruction is not accepted, and the following instruction decodes normally.
- `DECODE_SCOREBOARD_EN`:
  - Load to r4 handshaked, then a consumer of r4 -> stall until `wb_we` to r4.
  - The consumer is accepted in that wb cycle with `op1` equal to `wb_data`.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: instruction field positions, opcodes
// and the registered decoded bundle.
package decode_pkg;

  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned OPC_HI      = 15;
  localparam int unsigned OPC_LO      = 12;
  localparam int unsigned IMMF_BIT    = 11;
  localparam int unsigned RD_LO       = 8;
  localparam int unsigned RS1_LO      = 5;
  localparam int unsigned RS2_LO      = 2;
  localparam int unsigned IMM_W       = 5;
  localparam int unsigned REG_FIELD_W = 3;
  localparam int unsigned BTGT_W      = 11;

  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_ALU    = 4'h1;
  localparam logic [3:0] OPC_LOAD   = 4'hA;
  localparam logic [3:0] OPC_STORE  = 4'h9;
  localparam logic [3:0] OPC_BRANCH = 4'hB;

  typedef struct packed {
    logic [3:0]             opcode;
    logic                   imm_flag;
    logic [IMM_W-1:0]       imm;
    logic [REG_FIELD_W-1:0] rd;
    logic [INSTR_W-1:0]     instr;
  } decoded_t;

  function automatic decoded_t decode_fields(input logic [INSTR_W-1:0] instr);
    decoded_t d;
    d.opcode   = instr[OPC_HI:OPC_LO];
    d.imm_flag = instr[IMMF_BIT];
    d.imm      = instr[IMM_W-1:0];
    d.rd       = instr[RD_LO +: REG_FIELD_W];
    d.instr    = instr;
    return d;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// NREGS x XLEN register file, two combinational read ports, one write port.
// A same-cycle write is visible on the read ports (write-through).
module decode_regfile #(
  parameter int unsigned XLEN  = 16,
  parameter int unsigned NREGS = 8,
  localparam int unsigned RA   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [RA-1:0]   raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [RA-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o,
  input  logic            we_i,
  input  logic [RA-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
  end

endmodule

// File: rtl/decode_stage_fwd.sv
// Decode stage with operand forwarding, back-pressure and branch flush.
// Optional load-use interlock enabled by defining DECODE_SCOREBOARD_EN.
module decode_stage_fwd
  import decode_pkg::*;
#(
  parameter int unsigned XLEN     = 16,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned NFWD     = 2,
  parameter logic [3:0]  LOAD_OPC = OPC_LOAD,
  localparam int unsigned RA      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          instr,
  input  logic                 flush,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RA-1:0]   fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 wb_we,
  input  logic [RA-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           opcode,
  output logic                 imm_flag,
  output logic [4:0]           imm,
  output logic [RA-1:0]        rd,
  output logic [XLEN-1:0]      op1,
  output logic [XLEN-1:0]      op2,
  output logic [XLEN-1:0]      branch_target,
  output logic [15:0]          instr_out
);

  decoded_t        dec;
  decoded_t        bundle_q, bundle_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [RA-1:0]   rs1, rs2;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [XLEN-1:0] op1_res, op2_res;
  logic            hazard, accept;

  assign dec = decode_fields(instr);
  assign rs1 = instr[RS1_LO +: RA];
  assign rs2 = instr[RS2_LO +: RA];

  decode_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .raddr_a_i (rs1),
    .rdata_a_o (rf_a),
    .raddr_b_i (rs2),
    .rdata_b_o (rf_b),
    .we_i      (wb_we),
    .waddr_i   (wb_rd),
    .wdata_i   (wb_data)
  );

  // Walk from the highest index down so the lowest matching entry wins;
  // the register file read already includes the writeback write-through.
  always_comb begin
    op1_res = rf_a;
    op2_res = rf_b;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[i*RA +: RA] == rs1)) op1_res = fwd_data[i*XLEN +: XLEN];
      if (fwd_valid[i] && (fwd_rd[i*RA +: RA] == rs2)) op2_res = fwd_data[i*XLEN +: XLEN];
    end
    if (dec.imm_flag) op2_res = {{(XLEN-IMM_W){1'b0}}, dec.imm};
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;
  logic             held_load;
  logic [RA-1:0]    held_rd;

  assign held_load = valid_q && (bundle_q.opcode == LOAD_OPC);
  assign held_rd   = bundle_q.rd[RA-1:0];

  function automatic logic src_blocked(input logic [RA-1:0] rs);
    return (busy_q[rs] && !(wb_we && (wb_rd == rs))) || (held_load && (held_rd == rs));
  endfunction

  assign hazard = src_blocked(rs1) || (!dec.imm_flag && src_blocked(rs2));

  // Set wins over a same-cycle writeback clear on the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_we) busy_d[wb_rd] = 1'b0;
    if (held_load && out_ready) busy_d[held_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  assign in_ready = reset_n && (!valid_q || out_ready) && !flush && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
      op1_d    = op1_res;
      op2_d    = op2_res;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  assign out_valid     = valid_q;
  assign opcode        = bundle_q.opcode;
  assign imm_flag      = bundle_q.imm_flag;
  assign imm           = bundle_q.imm;
  assign rd            = bundle_q.rd[RA-1:0];
  assign op1           = op1_q;
  assign op2           = op2_q;
  assign instr_out     = bundle_q.instr;
  assign branch_target = {{(XLEN-BTGT_W){1'b0}}, bundle_q.instr[BTGT_W-1:0]};

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Directed self-checking bench for decode_stage_fwd (XLEN=16, NREGS=8, NFWD=2).
module tb_decode_stage_fwd;

  localparam int unsigned XLEN = 16;
  localparam int unsigned NFWD = 2;
  localparam int unsigned RA   = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          instr;
  logic                 flush;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*RA-1:0]   fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 wb_we;
  logic [RA-1:0]        wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           opcode;
  logic                 imm_flag;
  logic [4:0]           imm;
  logic [RA-1:0]        rd;
  logic [XLEN-1:0]      op1, op2, branch_target;
  logic [15:0]          instr_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage_fwd #(
    .XLEN  (XLEN),
    .NREGS (8),
    .NFWD  (NFWD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .flush         (flush),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .opcode        (opcode),
    .imm_flag      (imm_flag),
    .imm           (imm),
    .rd            (rd),
    .op1           (op1),
    .op2           (op2),
    .branch_target (branch_target),
    .instr_out     (instr_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    instr     = 16'h0;
    flush     = 1'b0;
    fwd_valid = '0;
    fwd_rd    = '0;
    fwd_data  = '0;
    wb_we     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    out_ready = 1'b1;

    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_op1", 32'(op1), 32'd0);
    check_eq("rst_instr_out", 32'(instr_out), 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // r2=5, r3=7
    step();
    wb_we = 1'b1; wb_rd = 3'd2; wb_data = 16'd5;
    step();
    wb_rd = 3'd3; wb_data = 16'd7;
    step();
    wb_we = 1'b0;

    // Register form: rd=r1, rs1=r2, rs2=r2
    in_valid = 1'b1; instr = 16'h1148;
    #1 check_eq("reg_in_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("reg_valid", 32'(out_valid), 32'd1);
    check_eq("reg_op1", 32'(op1), 32'd5);
    check_eq("reg_op2", 32'(op2), 32'd5);
    check_eq("reg_opcode", 32'(opcode), 32'd1);
    check_eq("reg_rd", 32'(rd), 32'd1);
    check_eq("reg_btgt", 32'(branch_target), 32'h0148);

    // Immediate form: rs1=r2, imm=0x17
    instr = 16'h1857;
    step();
    check_eq("imm_flag", 32'(imm_flag), 32'd1);
    check_eq("imm_op2", 32'(op2), 32'h0017);
    check_eq("imm_op1", 32'(op1), 32'd5);
    check_eq("imm_field", 32'(imm), 32'h17);
    check_eq("imm_instr_out", 32'(instr_out), 32'h1857);

    // Forwarding priority: fwd0 > fwd1 > writeback > regfile
    instr = 16'h1148;
    fwd_valid = 2'b11; fwd_rd = {3'd2, 3'd2}; fwd_data = {16'hBBBB, 16'hAAAA};
    wb_we = 1'b1; wb_rd = 3'd2; wb_data = 16'hCCCC;
    step();
    check_eq("fwd0_op1", 32'(op1), 32'hAAAA);
    check_eq("fwd0_op2", 32'(op2), 32'hAAAA);
    fwd_valid = 2'b10;
    step();
    check_eq("fwd1_op1", 32'(op1), 32'hBBBB);
    fwd_valid = 2'b01; fwd_rd = {3'd2, 3'd3};
    step();
    check_eq("fwd_nomatch_op1", 32'(op1), 32'hCCCC);
    fwd_valid = 2'b00;
    step();
    check_eq("wb_op1", 32'(op1), 32'hCCCC);
    wb_we = 1'b0;

    // Back-pressure: hold three cycles
    out_ready = 1'b0; instr = 16'h1857;
    #1 check_eq("hold_in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_instr", 32'(instr_out), 32'h1148);
      check_eq("hold_op1", 32'(op1), 32'hCCCC);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 check_eq("release_in_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("release_valid", 32'(out_valid), 32'd1);
    check_eq("release_instr", 32'(instr_out), 32'h1857);
    check_eq("release_op2", 32'(op2), 32'h0017);

    // Flush while held with a new instruction presented
    out_ready = 1'b0; instr = 16'h2148; flush = 1'b1;
    #1 check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; out_ready = 1'b1; instr = 16'h3148;
    #1 check_eq("post_flush_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("post_flush_valid", 32'(out_valid), 32'd1);
    check_eq("post_flush_instr", 32'(instr_out), 32'h3148);
    check_eq("post_flush_op1", 32'(op1), 32'hCCCC);
    in_valid = 1'b0;
    step();
    check_eq("drain_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    in_valid = 1'b1;
    step();
    check_eq("pre_areset_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_eq("areset_valid", 32'(out_valid), 32'd0);
    check_eq("areset_in_ready", 32'(in_ready), 32'd0);
    check_eq("areset_op1", 32'(op1), 32'd0);
    in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();

`ifdef DECODE_SCOREBOARD_EN
    // Load to r4, then a consumer of r4 stalls until writeback
    in_valid = 1'b1; instr = 16'hA400;
    step();
    check_eq("ld_valid", 32'(out_valid), 32'd1);
    instr = 16'h1080;
    #1 check_eq("sb_held_stall", 32'(in_ready), 32'd0);
    step();
    check_eq("sb_bubble", 32'(out_valid), 32'd0);
    check_eq("sb_busy_stall", 32'(in_ready), 32'd0);
    step();
    check_eq("sb_busy_stall2", 32'(in_ready), 32'd0);
    wb_we = 1'b1; wb_rd = 3'd4; wb_data = 16'h1234;
    #1 check_eq("sb_wb_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("sb_cons_valid", 32'(out_valid), 32'd1);
    check_eq("sb_cons_op1", 32'(op1), 32'h1234);
    wb_we = 1'b0;
    #1 check_eq("sb_cleared", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
